ycbcr2rgb_frame_ctrl: RTL and testbench

- Frame-synchronous configuration and monitoring controller for one ycbcr2rgb_2pix channel.
- Holds CTRL as a shadow register written over a simple register port. Commits CTRL to the converter only at frame start, so a mode change never tears a frame.
- Measures active width and height on the converter's input timing and flags format inconsistencies.
- One instance per channel, clocked by that channel's pixel clock.

---
 rtl/ycbcr2rgb_frame_ctrl_if.sv | 26 ++
 rtl/ycbcr2rgb_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_ycbcr2rgb_frame_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr2rgb_frame_ctrl_if.sv
// Register port, input video timing and committed converter controls
// for one ycbcr2rgb_frame_ctrl channel.
interface ycbcr2rgb_frame_ctrl_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        vin_v_sync;
  logic        vin_h_sync;
  logic        vin_de;
  logic        cvt_en;
  logic        cvt_bypass;
  logic        cvt_limited;
  logic        frame_start;
  logic        fmt_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, vin_v_sync, vin_h_sync, vin_de,
    input  cfg_rdata, cvt_en, cvt_bypass, cvt_limited, frame_start, fmt_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, vin_v_sync, vin_h_sync, vin_de,
    output cfg_rdata, cvt_en, cvt_bypass, cvt_limited, frame_start, fmt_err
  );
endinterface

// File: rtl/ycbcr2rgb_frame_ctrl.sv
// Frame-synchronous control for one ycbcr2rgb_2pix channel: shadow CTRL
// committed at frame start, active width/height measurement, sticky
// format-error flags and a frame counter.
module ycbcr2rgb_frame_ctrl #(
  parameter int PIXCEL_NUM = 2,
  parameter int HCNT_W     = 13,
  parameter int VCNT_W     = 12,
  parameter int FCNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ycbcr2rgb_frame_ctrl_if.slave   bus
);

  typedef enum logic {S_WAIT_VS, S_FRAME} state_t;

  state_t              state;
  logic                vs_q, de_q, frame_start_q, line_end_q;
  logic [2:0]          ctrl_shadow, stat;
  logic                en_q, bypass_q, limited_q;
  logic                first_line;
  logic [HCNT_W-1:0]   pix_cnt, ref_width, width;
  logic [VCNT_W-1:0]   line_cnt, height;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [15:0]         rdata;

  // Line boundaries come from DE alone; h_sync carries no extra information.
  logic unused_hs;
  assign unused_hs = bus.vin_h_sync;

  // Saturating pixel and line increments.
  logic [HCNT_W:0]     pix_sum;
  logic [HCNT_W-1:0]   pix_inc;
  logic [VCNT_W-1:0]   line_inc, line_now;
  logic [HCNT_W-1:0]   ref_now;
  assign pix_sum  = {1'b0, pix_cnt} + (HCNT_W+1)'(PIXCEL_NUM);
  assign pix_inc  = pix_sum[HCNT_W] ? '1 : pix_sum[HCNT_W-1:0];
  assign line_inc = (&line_cnt) ? line_cnt : line_cnt + VCNT_W'(1);

  // A line closing in the frame_start cycle belongs to the closing frame.
  assign line_now = line_end_q ? line_inc : line_cnt;
  assign ref_now  = (line_end_q && first_line) ? pix_cnt : ref_width;

  logic       in_frame;
  logic [2:0] stat_set, stat_clr;
  assign in_frame    = (state == S_FRAME);
  assign stat_set[0] = in_frame && line_end_q && !first_line && (pix_cnt != ref_width);
  assign stat_set[1] = in_frame && frame_start_q && (line_now != '0) &&
                       (height != '0) && (line_now != height);
  assign stat_set[2] = in_frame && frame_start_q && (line_now == '0);
  assign stat_clr    = (bus.cfg_wr && bus.cfg_addr == 2'd3) ? bus.cfg_wdata[2:0] : 3'b000;

  // Register the timing inputs once and form the edge pulses from them.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else begin
      vs_q          <= bus.vin_v_sync;
      de_q          <= bus.vin_de;
      frame_start_q <= bus.vin_v_sync & ~vs_q;
      line_end_q    <= de_q & ~bus.vin_de;
    end
  end

  // Frame FSM: counting, measurement latches, sticky errors and CTRL commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WAIT_VS;
      ctrl_shadow <= 3'b000;
      stat        <= 3'b000;
      en_q        <= 1'b0;
      bypass_q    <= 1'b0;
      limited_q   <= 1'b0;
      first_line  <= 1'b1;
      pix_cnt     <= '0;
      ref_width   <= '0;
      width       <= '0;
      line_cnt    <= '0;
      height      <= '0;
      frame_cnt   <= '0;
    end else begin
      // Set wins over a simultaneous write-1-to-clear.
      stat <= (stat & ~stat_clr) | stat_set;
      if (bus.cfg_wr && bus.cfg_addr == 2'd0)
        ctrl_shadow <= bus.cfg_wdata[2:0];

      case (state)
        S_WAIT_VS: begin
          if (frame_start_q) begin
            {limited_q, bypass_q, en_q} <= ctrl_shadow;
            line_cnt   <= '0;
            pix_cnt    <= '0;
            first_line <= 1'b1;
            state      <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (line_end_q) begin
            pix_cnt    <= '0;
            line_cnt   <= line_inc;
            first_line <= 1'b0;
            if (first_line) ref_width <= pix_cnt;
          end else if (de_q) begin
            pix_cnt <= pix_inc;
          end
          if (frame_start_q) begin
            if (line_now != '0) begin
              height <= line_now;
              width  <= ref_now;
            end
            frame_cnt  <= frame_cnt + FCNT_W'(1);
            {limited_q, bypass_q, en_q} <= ctrl_shadow;
            line_cnt   <= '0;
            pix_cnt    <= '0;
            first_line <= 1'b1;
          end
        end
        default: state <= S_WAIT_VS;
      endcase
    end
  end

  // Registered read mux; data follows cfg_addr by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      case (bus.cfg_addr)
        2'd0:    rdata <= {13'd0, ctrl_shadow};
        2'd1:    rdata <= 16'(width);
        2'd2:    rdata <= 16'(height);
        default: rdata <= {frame_cnt[12:0], stat};
      endcase
    end
  end

  assign bus.cfg_rdata   = rdata;
  assign bus.cvt_en      = en_q;
  assign bus.cvt_bypass  = bypass_q;
  assign bus.cvt_limited = limited_q;
  assign bus.frame_start = frame_start_q;
  assign bus.fmt_err     = |stat;

endmodule

// File: tb/tb_ycbcr2rgb_frame_ctrl.sv
// Self-checking bench for ycbcr2rgb_frame_ctrl: register reads checked
// through an expected-value queue, committed outputs checked inline.
module tb_ycbcr2rgb_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fc = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] mask;
  } exp_t;
  exp_t exp_q[$];

  ycbcr2rgb_frame_ctrl_if bus();

  ycbcr2rgb_frame_ctrl #(.PIXCEL_NUM(2), .HCNT_W(13), .VCNT_W(12), .FCNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic want(input logic [1:0] a, input logic [15:0] d, input logic [15:0] m = 16'hFFFF);
    exp_q.push_back('{a, d, m});
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    bus.cfg_addr = a;
    tick();
    d = bus.cfg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic send_line(input int n);
    bus.vin_de = 1'b1;
    ticks(n);
    bus.vin_de = 1'b0;
    ticks(3);
  endtask

  task automatic send_lines(input int lines, input int n);
    for (int i = 0; i < lines; i++) send_line(n);
  endtask

  task automatic vsync();
    bus.vin_v_sync = 1'b1;
    ticks(2);
    bus.vin_v_sync = 1'b0;
    ticks(2);
  endtask

  function automatic logic [15:0] stat_w(input int frames, input logic [2:0] bits);
    return {frames[12:0], bits};
  endfunction

  function automatic logic [4:0] outs();
    return {bus.frame_start, bus.cvt_en, bus.cvt_bypass, bus.cvt_limited, bus.fmt_err};
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    exp_t ex;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    tick();
    checks++;
    if (outs() !== 5'b00000) begin
      errors++; $display("FAIL reset_outs: got %b want %b", outs(), 5'b00000);
    end
    want(0, 16'h0000); want(1, 16'h0000); want(2, 16'h0000); want(3, 16'h0000);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL reset_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  task automatic test_commit();
    logic [15:0] got;
    exp_t ex;
    send_line(5);                   // DE before any v_sync must be ignored
    bus.vin_de = 1'b1; ticks(2);
    wr(0, 16'h0005);                // write mid-line
    ticks(2); bus.vin_de = 1'b0; ticks(2);
    checks++;
    if (outs() !== 5'b00000) begin
      errors++; $display("FAIL commit_before_vs: got %b want %b", outs(), 5'b00000);
    end
    bus.vin_v_sync = 1'b1;
    tick();                         // edge sampled: frame_start pulse, not yet committed
    checks++;
    if (outs() !== 5'b10000) begin
      errors++; $display("FAIL commit_1cyc: got %b want %b", outs(), 5'b10000);
    end
    tick();                         // two cycles after the edge: committed
    checks++;
    if (outs() !== 5'b01010) begin
      errors++; $display("FAIL commit_2cyc: got %b want %b", outs(), 5'b01010);
    end
    bus.vin_v_sync = 1'b0; ticks(2);
    fc = 0;
    want(0, 16'h0005); want(1, 16'h0000); want(2, 16'h0000); want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL commit_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  task automatic test_size();
    logic [15:0] got;
    exp_t ex;
    send_lines(4, 8); vsync(); fc++;
    send_lines(4, 8); vsync(); fc++;
    want(1, 16'd16); want(2, 16'd4); want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL size_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
    checks++;
    if (bus.fmt_err !== 1'b0) begin
      errors++; $display("FAIL size_fmt_err: got %b want %b", bus.fmt_err, 1'b0);
    end
  endtask

  task automatic test_width_err();
    logic [15:0] got;
    exp_t ex;
    send_lines(2, 8); send_line(7); send_line(8);
    vsync(); fc++;
    checks++;
    if (bus.fmt_err !== 1'b1) begin
      errors++; $display("FAIL width_err_flag: got %b want %b", bus.fmt_err, 1'b1);
    end
    want(3, stat_w(fc, 3'b001)); want(1, 16'd16); want(2, 16'd4);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL width_err_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
    wr(3, 16'h0001);
    checks++;
    if (bus.fmt_err !== 1'b0) begin
      errors++; $display("FAIL width_clr_flag: got %b want %b", bus.fmt_err, 1'b0);
    end
    want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL width_clr_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  task automatic test_height_err();
    logic [15:0] got;
    exp_t ex;
    send_lines(5, 8); vsync(); fc++;
    checks++;
    if (bus.fmt_err !== 1'b1) begin
      errors++; $display("FAIL height_err_flag: got %b want %b", bus.fmt_err, 1'b1);
    end
    want(2, 16'd5); want(3, stat_w(fc, 3'b010));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL height_err_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
    wr(3, 16'h0002);
    want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL height_clr_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  // Last DE falls in the same cycle v_sync rises: line_end and frame_start coincide.
  task automatic test_back_to_back();
    logic [15:0] got;
    exp_t ex;
    send_lines(4, 8);
    bus.vin_de = 1'b1; ticks(8);
    bus.vin_de = 1'b0; bus.vin_v_sync = 1'b1;
    ticks(2);
    bus.vin_v_sync = 1'b0; ticks(2);
    fc++;
    want(2, 16'd5); want(1, 16'd16); want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL b2b_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  task automatic test_ctrl_same_cycle();
    logic [15:0] got;
    exp_t ex;
    send_lines(5, 8);
    bus.vin_v_sync = 1'b1;
    tick();                         // frame_start is high during this cycle
    bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'h0003;
    tick();
    bus.cfg_wr = 1'b0;
    fc++;
    checks++;
    if (outs() !== 5'b01010) begin
      errors++; $display("FAIL same_cycle_keep: got %b want %b", outs(), 5'b01010);
    end
    bus.vin_v_sync = 1'b0; ticks(2);
    send_lines(5, 8);
    bus.vin_v_sync = 1'b1;
    ticks(2);
    fc++;
    checks++;
    if (outs() !== 5'b01100) begin
      errors++; $display("FAIL same_cycle_next: got %b want %b", outs(), 5'b01100);
    end
    bus.vin_v_sync = 1'b0; ticks(2);
    want(0, 16'h0003); want(2, 16'd5); want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL same_cycle_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  task automatic test_empty_frame();
    logic [15:0] got;
    exp_t ex;
    vsync(); fc++;                  // frame with no DE lines
    want(3, stat_w(fc, 3'b100), 16'hFFFD); want(2, 16'd5); want(1, 16'd16);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL empty_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
    wr(3, 16'h0007);
    want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL empty_clr_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    exp_t ex;
    bus.vin_de = 1'b1; ticks(3);
    rst = 1'b1; ticks(2);
    rst = 1'b0; ticks(2);
    bus.vin_de = 1'b0; ticks(3);
    checks++;
    if (outs() !== 5'b00000) begin
      errors++; $display("FAIL rst_mid_outs: got %b want %b", outs(), 5'b00000);
    end
    want(1, 16'h0000); want(2, 16'h0000); want(3, 16'h0000); want(0, 16'h0000);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL rst_mid_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
    send_lines(2, 8);               // must not be counted before v_sync
    vsync(); fc = 0;
    checks++;
    if (outs() !== 5'b00000) begin
      errors++; $display("FAIL rst_mid_commit: got %b want %b", outs(), 5'b00000);
    end
    send_lines(3, 6); vsync(); fc++;
    want(1, 16'd12); want(2, 16'd3); want(3, stat_w(fc, 3'b000));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); rd(ex.addr, got); checks++;
      if ((got & ex.mask) !== (ex.data & ex.mask)) begin
        errors++; $display("FAIL rst_mid_meas_reg%0d: got %h want %h", ex.addr, got, ex.data);
      end
    end
  endtask

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'h0000;
    bus.vin_v_sync = 1'b0; bus.vin_h_sync = 1'b0; bus.vin_de = 1'b0;
    test_reset();
    test_commit();
    test_size();
    test_width_err();
    test_height_err();
    test_back_to_back();
    test_ctrl_same_cycle();
    test_empty_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
